// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags,
// synchronous flush and sticky overflow/underflow indicators.
module fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     w_en,
    input  logic                     r_en,
    input  logic                     flush,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] AF_THR   = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_THR   = AE_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_W:0]       wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W:0]       rd_ptr_reg, rd_ptr_next;
    logic [ADDR_W:0]       count_reg, count_next;
    logic                  overflow_reg, overflow_next;
    logic                  underflow_reg, underflow_next;
    logic [DATA_WIDTH-1:0] data_out_reg;
    logic                  wr_accept, rd_accept;

    // Acceptance uses the flags decoded from the pre-edge count.
    assign full         = (count_reg == FULL_CNT);
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= AF_THR);
    assign almost_empty = (count_reg <= AE_THR);
    assign wr_accept    = w_en && !full;
    assign rd_accept    = r_en && !empty;

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;
        if (flush) begin
            wr_ptr_next    = '0;
            rd_ptr_next    = '0;
            count_next     = '0;
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end else begin
            if (wr_accept) wr_ptr_next = wr_ptr_reg + ONE;
            if (rd_accept) rd_ptr_next = rd_ptr_reg + ONE;
            if (wr_accept && !rd_accept)      count_next = count_reg + ONE;
            else if (rd_accept && !wr_accept) count_next = count_reg - ONE;
            if (w_en && full)  overflow_next  = 1'b1;
            if (r_en && empty) underflow_next = 1'b1;
        end
    end

    // Storage has no reset so it can map onto block RAM; flush leaves it intact.
    always_ff @(posedge clk) begin
        if (wr_accept && !flush) mem[wr_ptr_reg[ADDR_W-1:0]] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            data_out_reg  <= '0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
            if (flush)          data_out_reg <= '0;
            else if (rd_accept) data_out_reg <= mem[rd_ptr_reg[ADDR_W-1:0]];
        end
    end

    assign data_out  = data_out_reg;
    assign count     = count_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param (DEPTH=4, 8-bit) with a queue scoreboard and
// an independent occupancy/flag model.
module tb_fifo_param;
    localparam int DW = 8;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          w_en = 1'b0;
    logic          r_en = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [2:0]    count;

    fifo_param #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .r_en(r_en), .flush(flush),
        .data_in(data_in), .data_out(data_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] sb[$];
    int            m_count = 0;
    logic          m_ovf = 1'b0, m_unf = 1'b0;
    logic [DW-1:0] m_dout = '0;
    int            max_count = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(m_count));
        chk({tag, ".full"}, 32'(full), 32'(m_count == DP));
        chk({tag, ".empty"}, 32'(empty), 32'(m_count == 0));
        chk({tag, ".afull"}, 32'(almost_full), 32'(m_count >= DP - 1));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(m_count <= 1));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
        chk({tag, ".dout"}, 32'(data_out), 32'(m_dout));
    endtask

    task automatic model_reset();
        sb.delete();
        m_count = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_dout  = '0;
    endtask

    // One clock of stimulus; the model advances from its own pre-edge state.
    task automatic step(input string tag, input logic w, input logic r,
                        input logic [DW-1:0] d, input logic fl);
        logic acc_w, acc_r;
        w_en = w; r_en = r; data_in = d; flush = fl;
        acc_w = w && (m_count < DP);
        acc_r = r && (m_count > 0);
        @(posedge clk);
        #1;
        if (fl) begin
            model_reset();
        end else begin
            if (acc_r) m_dout = sb.pop_front();
            if (acc_w) sb.push_back(d);
            if (acc_w && !acc_r) m_count++;
            if (acc_r && !acc_w) m_count--;
            if (w && !acc_w) m_ovf = 1'b1;
            if (r && !acc_r) m_unf = 1'b1;
        end
        if (m_count > max_count) max_count = m_count;
        w_en = 1'b0; r_en = 1'b0; flush = 1'b0;
        $display("[TB] %s w=%0b r=%0b fl=%0b din=%02h -> dout=%02h count=%0d ovf=%0b unf=%0b",
                 tag, w, r, fl, d, data_out, count, overflow, underflow);
        chk_all(tag);
    endtask

    initial begin
        logic [DW-1:0] held;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");
        #3 rst_n = 1'b1;

        // Fill
        step("wr10", 1, 0, 8'd10, 0);
        step("wr20", 1, 0, 8'd20, 0);
        step("wr30", 1, 0, 8'd30, 0);
        step("wr40", 1, 0, 8'd40, 0);
        step("wr50_full", 1, 0, 8'd50, 0);
        // Drain plus one underflowing read
        for (int i = 0; i < 5; i++) step("rd", 0, 1, 8'h00, 0);

        // Interleaved traffic crosses the pointer wrap
        for (int i = 0; i < 6; i++) begin
            step("wrap_wr", 1, 0, DW'($urandom_range(0, 255)), 0);
            step("wrap_rd", 0, 1, 8'h00, 0);
        end
        chk("wrap.max_count", 32'(max_count <= DP), 32'd1);

        // Simultaneous read/write at count 2
        step("mid_wr", 1, 0, 8'h61, 0);
        step("mid_wr", 1, 0, 8'h62, 0);
        for (int i = 0; i < 3; i++) step("mid_rw", 1, 1, DW'(8'h70 + i), 0);
        // At full: read only
        step("tofull_wr", 1, 0, 8'h81, 0);
        step("tofull_wr", 1, 0, 8'h82, 0);
        step("full_rw", 1, 1, 8'h90, 0);
        // At empty: write only, data_out holds
        for (int i = 0; i < 3; i++) step("drain", 0, 1, 8'h00, 0);
        held = data_out;
        step("empty_rw", 1, 1, 8'h91, 0);
        chk("empty_rw.hold", 32'(data_out), 32'(held));

        // Fill to 3 with both error flags set, then flush beside a write
        step("pre_wr", 1, 0, 8'hB1, 0);
        step("pre_wr", 1, 0, 8'hB2, 0);
        step("flush_w", 1, 0, 8'hCC, 1);
        step("post_flush_rd", 0, 1, 8'h00, 0);

        // Asynchronous reset between edges with count 3
        step("ar_wr", 1, 0, 8'h11, 0);
        step("ar_wr", 1, 0, 8'h12, 0);
        step("ar_wr", 1, 0, 8'h13, 0);
        step("ar_rd", 0, 1, 8'h00, 0);
        step("ar_wr", 1, 0, 8'h14, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        $display("[TB] async_reset mid-cycle -> count=%0d dout=%02h", count, data_out);
        chk_all("async_rst");
        #1 rst_n = 1'b1;
        step("rst_wrA5", 1, 0, 8'hA5, 0);
        step("rst_rdA5", 0, 1, 8'h00, 0);
        chk("rst_rdA5.value", 32'(data_out), 32'hA5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
